dram_axi_master: RTL
====================

Name: dram_axi_master

Overview:
- DUT-side AXI master that drives the DRAM AXI interface. The DRAM agent on that interface is the slave.
- Converts a simple single-beat request/response port from the DUT core into AW/W/B and AR/R channel handshakes.
- Allows one outstanding transaction at a time, with a per-transaction timeout that reports an error.
- Sits directly upstream of the DRAM interface and owns every master-driven signal on it.

Parameters:
- ADDR_W, 16, address width (matches DRAM interface awaddr/araddr).
- DATA_W, 16, data width (matches wdata/rdata).
- TIMEOUT, 256, cycles allowed in any AXI wait state before abort; legal range 2..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_we  out  1  echoes req_we of the completed transaction
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  transaction timed out
- awaddr  out  ADDR_W, awvalid  out  1, awready  in  1
- wdata  out  DATA_W, wvalid  out  1, wready  in  1
- bvalid  in  1, bready  out  1
- araddr  out  ADDR_W, arvalid  out  1, arready  in  1
- rdata  in  DATA_W, rvalid  in  1, rready  out  1

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - All valid/ready outputs are 0, except req_ready = 1.
  - awaddr, araddr, wdata, rsp_rdata are 0; rsp_we and rsp_err are 0.
  - FSM is in IDLE; timeout counter is 0.
- Reset mid-transaction drops all valids immediately and no response is produced.
- All outputs are registered. The FSM states are IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture addr/wdata/we.
  - Write: go to WR and set awvalid = wvalid = 1 in the next cycle.
  - Read: go to RD and set arvalid = 1 in the next cycle.
- WR:
  - AW and W are presented concurrently and tracked independently by flags aw_done and w_done.
  - awvalid drops the cycle after awvalid & awready; wvalid drops the cycle after wvalid & wready.
  - Any order is accepted, including both in the same cycle.
  - When both flags are set, go to WR_RESP with bready = 1.
- WR_RESP:
  - On bvalid & bready, set bready = 0 and go to RSP with rsp_we = 1, rsp_rdata = 0, rsp_err = 0.
- RD:
  - On arvalid & arready, set arvalid = 0 and go to RD_DATA with rready = 1.
- RD_DATA:
  - On rvalid & rready, capture rdata into rsp_rdata, set rready = 0 and go to RSP with rsp_we = 0.
- RSP:
  - rsp_valid = 1, with rsp_* held stable until rsp_ready.
  - On the handshake, go to IDLE with req_ready = 1 in the next cycle.
  - rsp_ready high in the same cycle rsp_valid rises completes in that cycle.
- req_ready is 0 in every state except IDLE. There is no request pipelining.
- Valid outputs never drop before their handshake, except on timeout or reset.
- Address and data outputs are stable while their valid is high.
- bvalid and rvalid arriving while bready/rready is 0 are ignored.
- Timeout:
  - The counter clears on entry to WR, WR_RESP, RD and RD_DATA, and increments each cycle spent in those states.
  - When it reaches TIMEOUT-1 without completion, all AXI valid/ready outputs drop next cycle and the FSM goes to RSP with rsp_err = 1 and rsp_rdata = 0.
  - The counter does not run in RSP, so core stall is unbounded.
  - A handshake in the same cycle as the timeout terminal count wins: normal completion, rsp_err = 0.
- Minimum latency:
  - Write: request accepted at cycle N, AW/W presented at N+1, bvalid at N+2 earliest, rsp_valid at N+3.
  - Read: same pattern with AR/R.

Decomposition:
- Package dram_axi_pkg contains:
  - ADDR_W/DATA_W default localparams.
  - typedef enum logic [2:0] dram_mst_state_t {IDLE, WR, WR_RESP, RD, RD_DATA, RSP}.
  - Request struct dram_req_t {we, addr, wdata}.
- No sub-module: the timeout counter is inline. Top-level wiring binds these ports to the DRAM interface SLV-side signals.

Test Plan:
- Write 0x1234 to addr 0x00A0, slave asserts awready and wready the first cycle of presentation and bvalid the next cycle -> awaddr = 0x00A0, wdata = 0x1234, rsp_valid 3 cycles after request acceptance, rsp_we = 1, rsp_err = 0.
- Read addr 0x0042, arready delayed 5 cycles, rvalid with rdata = 0xBEEF 3 cycles later -> arvalid held stable 5 cycles, rsp_rdata = 0xBEEF, rsp_we = 0.
- Write with wready 4 cycles before awready -> wvalid drops after its handshake, awvalid stays high; bready rises only after both handshakes; single response.
- Read where the slave never asserts arready, TIMEOUT = 8 -> arvalid drops after 8 cycles in RD, rsp_err = 1, rsp_rdata = 0; the next request is accepted normally.
- Response back-pressure: rsp_ready held low 10 cycles -> rsp_valid and rsp data stable, req_ready = 0 throughout, no AXI activity.
- rst_n asserted while awvalid/wvalid are high -> all valids are 0 asynchronously, req_ready = 1 after release, no spurious rsp_valid.

Source files
------------

// File: rtl/dram_axi_pkg.sv
// Shared types and defaults for the DRAM-side AXI master: FSM state encoding,
// request bundle, and default address/data widths.
package dram_axi_pkg;

    localparam int DRAM_ADDR_W = 16;
    localparam int DRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD      = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } dram_mst_state_t;

    typedef struct packed {
        logic                   we;
        logic [DRAM_ADDR_W-1:0] addr;
        logic [DRAM_DATA_W-1:0] wdata;
    } dram_req_t;

endpackage

// File: rtl/dram_axi_master.sv
// Single-outstanding AXI master: turns a one-beat core request/response port
// into AW/W/B or AR/R handshakes, with a per-wait-state timeout.
module dram_axi_master
    import dram_axi_pkg::*;
#(
    parameter int ADDR_W  = DRAM_ADDR_W,
    parameter int DATA_W  = DRAM_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    // Core side: a transfer happens on any cycle where valid & ready are both
    // high; a valid, once raised, is held with stable payload until that cycle.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // DRAM AXI side
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,
    // Debug view of the FSM
    output dram_mst_state_t   state_dbg
);

    localparam int CNT_W = 16;

    dram_mst_state_t   state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              aw_done, aw_done_d;
    logic              w_done, w_done_d;

    logic              req_ready_d, rsp_valid_d, rsp_we_d, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d, wdata_d;
    logic [ADDR_W-1:0] awaddr_d, araddr_d;
    logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    logic accept, aw_fire, w_fire, b_fire, ar_fire, r_fire, cnt_tmo, wait_state;

    assign accept     = req_valid & req_ready;
    assign aw_fire    = awvalid & awready;
    assign w_fire     = wvalid & wready;
    assign b_fire     = bvalid & bready;
    assign ar_fire    = arvalid & arready;
    assign r_fire     = rvalid & rready;
    assign cnt_tmo    = (cnt == CNT_W'(TIMEOUT - 1));
    assign wait_state = (state == WR) || (state == WR_RESP) ||
                        (state == RD) || (state == RD_DATA);
    assign state_dbg  = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
        end
    end

    // Next-state: a completing handshake takes priority over the terminal count.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = req_we ? WR : RD;
            WR: begin
                if ((aw_done || aw_fire) && (w_done || w_fire)) state_d = WR_RESP;
                else if (cnt_tmo)                               state_d = RSP;
            end
            WR_RESP: if (b_fire || cnt_tmo) state_d = RSP;
            RD: begin
                if (ar_fire)      state_d = RD_DATA;
                else if (cnt_tmo) state_d = RSP;
            end
            RD_DATA: if (r_fire || cnt_tmo) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of every registered output, derived from the state move.
    always_comb begin
        req_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WR) && ((state != WR) || (awvalid && !aw_fire));
        wvalid_d    = (state_d == WR) && ((state != WR) || (wvalid && !w_fire));
        bready_d    = (state_d == WR_RESP);
        arvalid_d   = (state_d == RD);
        rready_d    = (state_d == RD_DATA);
        rsp_valid_d = (state_d == RSP);
        aw_done_d   = (state == WR) && (state_d == WR) && (aw_done || aw_fire);
        w_done_d    = (state == WR) && (state_d == WR) && (w_done || w_fire);

        awaddr_d    = awaddr;
        wdata_d     = wdata;
        araddr_d    = araddr;
        rsp_we_d    = rsp_we;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        cnt_d       = cnt;

        if (accept) begin
            rsp_we_d = req_we;
            if (req_we) begin
                awaddr_d = req_addr;
                wdata_d  = req_wdata;
            end else begin
                araddr_d = req_addr;
            end
        end

        // Entering RSP without a B or R handshake can only mean a timeout.
        if ((state_d == RSP) && (state != RSP)) begin
            rsp_rdata_d = ((state == RD_DATA) && r_fire) ? rdata : '0;
            rsp_err_d   = !(((state == RD_DATA) && r_fire) || ((state == WR_RESP) && b_fire));
        end

        if (state_d != state) cnt_d = '0;
        else if (wait_state)  cnt_d = cnt + CNT_W'(1);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_we    <= rsp_we_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            awaddr    <= awaddr_d;
            awvalid   <= awvalid_d;
            wdata     <= wdata_d;
            wvalid    <= wvalid_d;
            bready    <= bready_d;
            araddr    <= araddr_d;
            arvalid   <= arvalid_d;
            rready    <= rready_d;
        end
    end

endmodule
